pixel_pack_fifo: RTL and testbench
==================================

Name: pixel_pack_fifo

Overview:
- Downstream stage of the pixel processing block; consumes its 32-bit out_pixel/out_valid stream.
- Each pixel is normalised (arithmetic right shift, clamp to 0..255), packed four per 32-bit word and buffered in a synchronous FIFO.
- The FIFO drains over a valid/ready stream toward the bus/DMA side.
- No backpressure exists upstream, so overflow drops data and is reported sticky.

Parameters:
- DEPTH, 16, FIFO depth in 32-bit words (power of two, >=2)
- AW, 4, FIFO address width, equal to log2(DEPTH)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  pixel strobe from upstream processing stage
- in_pixel  in  32  pixel value, two's-complement signed (convolution sums may be negative or >255)
- cfg_shift  in  4  arithmetic right-shift amount applied before clamp, sampled each accepted pixel
- flush  in  1  single-cycle pulse; emit partially filled word zero-padded
- clr_ovf  in  1  single-cycle pulse; clears overflow
- m_valid  out  1  FIFO head word valid
- m_data  out  32  FIFO head word; lane0 = bits[7:0] = oldest pixel
- m_ready  in  1  downstream accepts head word when m_valid & m_ready
- level  out  AW+1  number of words currently in FIFO
- overflow  out  1  sticky: a completed word was dropped
- lane_cnt  out  2  pixels currently held in packing register

Behaviour:
- Reset (async, rstn low) clears all of the following, regardless of any in-flight pixels or words, with no emission on release:
  - m_valid=0, m_data=0, level=0, overflow=0, lane_cnt=0
  - packing register = 0, read/write pointers = 0
- Normalise: v = in_pixel >>> cfg_shift (sign-preserving). Then p = 0 if v<0, 255 if v>255, else v[7:0].
- Packing:
  - Each in_valid writes p into lane lane_cnt and increments lane_cnt.
  - On the 4th lane (lane_cnt==3), the full word {p, lane2, lane1, lane0} is pushed.
  - lane_cnt wraps to 0 and the packing register clears.
- Flush:
  - With lane_cnt!=0, the partial word is pushed with unfilled lanes = 0, and lane_cnt becomes 0.
  - With lane_cnt==0, flush is a no-op.
  - flush together with in_valid: the pixel is inserted first, then the (possibly now full) word is pushed once; lane_cnt becomes 0. Never two pushes in one cycle.
- FIFO:
  - Show-ahead; m_data is valid whenever m_valid=1.
  - A push in cycle N is visible as m_valid=1 in cycle N+1 when the FIFO was empty; latency from 4th pixel to m_valid = 1 cycle.
  - Pop occurs when m_valid & m_ready.
  - Push is allowed if level<DEPTH, or if level==DEPTH and a pop occurs the same cycle; level is then unchanged.
  - Simultaneous push+pop on empty: no pop (m_valid=0), push succeeds.
  - Pointers wrap modulo DEPTH; level is exact 0..DEPTH.
- Overflow:
  - A push refused because the FIFO is full drops that word; overflow is set next edge.
  - The packing register still clears and lane_cnt resets; no stall.
  - clr_ovf clears overflow. If clr_ovf and a new drop coincide, overflow remains 1 (set wins).
- m_data and m_valid must not change while m_valid=1 and m_ready=0.

Optional Feature:
- Macro PIXEL_PACK_STATS_EN.
- Defined: adds outputs sat_cnt[15:0] and drop_cnt[15:0].
  - sat_cnt increments on each pixel clamped (v<0 or v>255).
  - drop_cnt increments on each dropped word.
  - Both saturate at 0xFFFF, clear on reset, and clear on clr_ovf (clear wins over increment).
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pixel_pack_pkg: LANES=4, PIX_MAX=8'd255, PIX_W=8, WORD_W=32, and a clamp function (signed 32 -> 8 bit).
- Sub-module pixel_pack_sfifo: generic show-ahead synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/level.
  - It is instantiated once.
  - Packing, normalise and overflow logic stay in the top.

Test Plan:
- Packing order: shift=0, pixels 0x11, 0x22, 0x33, 0x44 on consecutive cycles, m_ready=1. Expect m_valid exactly 1 cycle after 4th pixel, m_data=0x44332211, level returns 0.
- Clamp/shift: pixels -5, 300, 1020 (shift=2), 128 (shift=0). Expect packed bytes 0x00, 0xFF, 0xFF, 0x80, so m_data=0x80FFFF00.
- Flush: pixels 0xAA, 0xBB, then flush. Expect m_data=0x0000BBAA and lane_cnt=0. Flush with lane_cnt=0 pushes nothing. Flush with 3rd pixel 0xCC pushes 0x00CCBBAA once.
- Full/overflow: m_ready=0, push DEPTH+1 words. Expect level=16, overflow=1, head word equals first pushed word. With m_ready=1 the next full word is accepted with level staying 16. clr_ovf then drops overflow to 0.
- Backpressure hold: m_ready toggled pseudo-randomly over 64 words. m_data stable while stalled; output sequence equals input order, with no loss or duplication.
- Reset mid-operation: assert rstn=0 with lane_cnt=2 and level=5. Expect m_valid, level and lane_cnt all 0 immediately (async), and no stale word after release.

Source files
------------

// File: rtl/pixel_pack_pkg.sv
// Shared constants and the pixel clamp helpers for the pixel pack FIFO.
package pixel_pack_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned WORD_W  = 32;
    localparam logic [7:0]  PIX_MAX = 8'd255;

    function automatic logic is_clamped(input logic signed [WORD_W-1:0] v);
        return (v < 0) || (v > 255);
    endfunction

    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [WORD_W-1:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > 255) begin
            return PIX_MAX;
        end else begin
            return v[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pixel_pack_sfifo.sv
// Generic show-ahead synchronous FIFO; a push into a full FIFO is taken only
// when a pop happens in the same cycle.
module pixel_pack_sfifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = pop && (level_q != '0);
        do_push = push && ((level_q != FULL_LVL) || do_pop);
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Storage is not reset, so the head is forced to zero while empty.
    assign empty = (level_q == '0);
    assign full  = (level_q == FULL_LVL);
    assign level = level_q;
    assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/pixel_pack_fifo.sv
// Normalises signed pixels to 8 bits, packs four per word and buffers them.
// Optional PIXEL_PACK_STATS_EN adds saturating sat_cnt/drop_cnt counters.
module pixel_pack_fifo
    import pixel_pack_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] in_pixel,
    input  logic [3:0]  cfg_shift,
    input  logic        flush,
    input  logic        clr_ovf,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic [AW:0] level,
    output logic        overflow,
    output logic [1:0]  lane_cnt
`ifdef PIXEL_PACK_STATS_EN
    ,
    output logic [15:0] sat_cnt,
    output logic [15:0] drop_cnt
`endif
);

    logic [WORD_W-1:0]        pack_q, pack_d, word;
    logic [1:0]               lane_q, lane_d;
    logic                     ovf_q, ovf_d;
    logic signed [WORD_W-1:0] v;
    logic [PIX_W-1:0]         pix;
    logic                     push_req, pop, drop, sat, full, empty;

    always_comb begin
        v    = $signed(in_pixel) >>> cfg_shift;
        pix  = clamp_pix(v);
        sat  = in_valid && is_clamped(v);
        word = pack_q;
        if (in_valid) begin
            word[{lane_q, 3'b000} +: PIX_W] = pix;
        end
        // Flush with a same-cycle pixel still yields exactly one push.
        push_req = (in_valid && (lane_q == 2'd3)) || (flush && (in_valid || (lane_q != 2'd0)));
        pack_d   = pack_q;
        lane_d   = lane_q;
        if (push_req) begin
            pack_d = '0;
            lane_d = 2'd0;
        end else if (in_valid) begin
            pack_d = word;
            lane_d = lane_q + 2'd1;
        end
        pop   = m_valid && m_ready;
        drop  = push_req && full && !pop;
        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_q <= '0;
            lane_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pack_q <= pack_d;
            lane_q <= lane_d;
            ovf_q  <= ovf_d;
        end
    end

    pixel_pack_sfifo #(
        .WIDTH(WORD_W),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_sfifo (
        .clk  (clk),
        .rstn (rstn),
        .push (push_req),
        .wdata(word),
        .pop  (pop),
        .rdata(m_data),
        .full (full),
        .empty(empty),
        .level(level)
    );

    assign m_valid  = !empty;
    assign overflow = ovf_q;
    assign lane_cnt = lane_q;

`ifdef PIXEL_PACK_STATS_EN
    logic [15:0] sat_q, sat_d, drop_q, drop_d;

    always_comb begin
        sat_d  = sat_q;
        drop_d = drop_q;
        if (clr_ovf) begin
            sat_d  = '0;
            drop_d = '0;
        end else begin
            if (sat && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
            if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_q  <= '0;
            drop_q <= '0;
        end else begin
            sat_q  <= sat_d;
            drop_q <= drop_d;
        end
    end

    assign sat_cnt  = sat_q;
    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_pixel_pack_fifo.sv
// Scoreboard bench for pixel_pack_fifo: stimulus queues expected words,
// a negedge monitor pops and compares every accepted head word.
module tb_pixel_pack_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pixel = '0;
    logic [3:0]  cfg_shift = '0;
    logic        flush = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic [AW:0] level;
    logic        overflow;
    logic [1:0]  lane_cnt;
`ifdef PIXEL_PACK_STATS_EN
    logic [15:0] sat_cnt, drop_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    bit          rnd_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_w;

    pixel_pack_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_pixel (in_pixel),
        .cfg_shift(cfg_shift),
        .flush    (flush),
        .clr_ovf  (clr_ovf),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .level    (level),
        .overflow (overflow),
        .lane_cnt (lane_cnt)
`ifdef PIXEL_PACK_STATS_EN
        ,
        .sat_cnt  (sat_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] pix, input logic [3:0] sh, input logic fl,
                        input logic vld);
        in_valid  = vld;
        in_pixel  = pix;
        cfg_shift = sh;
        flush     = fl;
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_it);
        if (expect_it) exp_q.push_back(w);
        for (int j = 0; j < 4; j++) begin
            send({24'd0, w[8*j +: 8]}, 4'd0, 1'b0, 1'b1);
        end
    endtask

    task automatic wait_drain();
        int k = 0;
        m_ready = 1'b1;
        while ((level != '0 || exp_q.size() != 0) && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_within_budget", 32'(k < 400), 32'd1);
    endtask

    function automatic logic [31:0] mkword(input int k);
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    // Monitor: consume accepted words and check the head holds while stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_cmp++;
                    if (!m_valid || m_data !== prev_data) begin
                        n_err++;
                        $display("FAIL hold: got valid=%b data=%h, required valid=1 data=%h",
                                 m_valid, m_data, prev_data);
                    end
                end
                if (m_valid && m_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_word: got %h, required no word", m_data);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (m_data !== exp_w) begin
                            n_err++;
                            $display("FAIL word_order: got %h, required %h", m_data, exp_w);
                        end
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_lane_cnt", 32'(lane_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Packing order and one-cycle latency
        m_ready = 1'b1;
        exp_q.push_back(32'h44332211);
        send(32'h11, 4'd0, 1'b0, 1'b1);
        send(32'h22, 4'd0, 1'b0, 1'b1);
        send(32'h33, 4'd0, 1'b0, 1'b1);
        chk("t1_no_early_valid", 32'(m_valid), 32'd0);
        chk("t1_lane_cnt3", 32'(lane_cnt), 32'd3);
        send(32'h44, 4'd0, 1'b0, 1'b1);
        chk("t1_latency", 32'(m_valid), 32'd1);
        chk("t1_head", m_data, 32'h44332211);
        idle(1);
        chk("t1_level_back0", 32'(level), 32'd0);

        // Clamp and shift
        exp_q.push_back(32'h80FFFF00);
        send(32'hFFFFFFFB, 4'd0, 1'b0, 1'b1);
        send(32'd300, 4'd0, 1'b0, 1'b1);
        send(32'd1020, 4'd2, 1'b0, 1'b1);
        send(32'd128, 4'd0, 1'b0, 1'b1);
        idle(2);

        // Flush
        m_ready = 1'b0;
        exp_q.push_back(32'h0000BBAA);
        send(32'hAA, 4'd0, 1'b0, 1'b1);
        send(32'hBB, 4'd0, 1'b0, 1'b1);
        send(32'h0, 4'd0, 1'b1, 1'b0);
        chk("t3_flush_lane0", 32'(lane_cnt), 32'd0);
        chk("t3_flush_level", 32'(level), 32'd1);
        chk("t3_flush_head", m_data, 32'h0000BBAA);
        send(32'h0, 4'd0, 1'b1, 1'b0);
        chk("t3_noop_flush", 32'(level), 32'd1);
        exp_q.push_back(32'h00CCBBAA);
        send(32'hAA, 4'd0, 1'b0, 1'b1);
        send(32'hBB, 4'd0, 1'b0, 1'b1);
        send(32'hCC, 4'd0, 1'b1, 1'b1);
        chk("t3_flush_with_pixel", 32'(level), 32'd2);
        chk("t3_flush_with_pixel_lane", 32'(lane_cnt), 32'd0);
        wait_drain();

        // Full and overflow
        m_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send_word(mkword(k), 1'b1);
        chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
        send_word(mkword(16), 1'b0);
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_level_full", 32'(level), 32'd16);
        chk("t4_head_first", m_data, mkword(0));
        chk("t4_lane_reset", 32'(lane_cnt), 32'd0);
        exp_q.push_back(mkword(17));
        for (int j = 0; j < 3; j++) send({24'd0, 8'(68 + j)}, 4'd0, 1'b0, 1'b1);
        m_ready = 1'b1;
        send({24'd0, 8'd71}, 4'd0, 1'b0, 1'b1);
        m_ready = 1'b0;
        chk("t4_full_push_pop", 32'(level), 32'd16);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("t4_clr_ovf", 32'(overflow), 32'd0);
        wait_drain();

        // Random backpressure
        rnd_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            send_word({8'(k), 8'(~k), 8'(k * 3), 8'(k + 100)}, 1'b1);
        end
        rnd_ready = 1'b0;
        wait_drain();
        chk("t5_no_overflow", 32'(overflow), 32'd0);

        // Asynchronous reset mid-operation
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_word(mkword(k + 20), 1'b1);
        send(32'h5, 4'd0, 1'b0, 1'b1);
        send(32'h6, 4'd0, 1'b0, 1'b1);
        chk("t6_pre_level", 32'(level), 32'd5);
        chk("t6_pre_lane", 32'(lane_cnt), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(m_valid), 32'd0);
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_lane", 32'(lane_cnt), 32'd0);
        chk("t6_rst_data", m_data, 32'd0);
        exp_q.delete();
        idle(2);
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        idle(3);
        chk("t6_no_stale", 32'(m_valid), 32'd0);
        exp_q.push_back(32'h00000201);
        send(32'h01, 4'd0, 1'b0, 1'b1);
        send(32'h02, 4'd0, 1'b1, 1'b1);
        wait_drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
